iccm_port_arbiter: RTL and testbench
====================================

// Module: iccm_port_arbiter
// PURPOSE
//  Owns the single ICCM SRAM port and shares it between two requesters:
//   - instruction fetch, via the TL-UL SRAM adapter;
//   - the UART boot programmer's write stream.
//  Sequences hand-over between them. Drains in-flight fetch reads before the programmer takes the port.
//  Holds the core in reset (core_hold_o) from drain start until programming ends plus a settle window.
// PARAMETERS
//  Aw           12  SRAM word-address width
//  Dw           32  SRAM data width
//  MaxOutstand  2   max fetch reads in flight (must match adapter Outstanding)
//  WrFifoDepth  2   programmer write buffer depth (power of 2, >=2)
//  HoldCycles   4   cycles core_hold_o stays high after last programmer write retires
// PORTS
//  clk_i          in   1   clock
//  rst_ni         in   1   async active-low reset
//  f_req_i        in   1   fetch request from adapter
//  f_gnt_o        out  1   fetch grant; request accepted when f_req_i & f_gnt_o
//  f_we_i         in   1   fetch-side write enable (DCCM-style writes pass through)
//  f_addr_i       in   Aw  fetch word address
//  f_wdata_i      in   Dw  fetch write data
//  f_wmask_i      in   Dw  fetch write bit-mask
//  f_rdata_o      out  Dw  read data to adapter
//  f_rvalid_o     out  1   read data valid to adapter
//  p_active_i     in   1   programmer session active (level)
//  p_we_i         in   1   programmer write strobe, 1 cycle per word, no backpressure
//  p_addr_i       in   Aw  programmer word address
//  p_wdata_i      in   Dw  programmer write data
//  m_req_o        out  1   SRAM request
//  m_we_o         out  1   SRAM write enable
//  m_addr_o       out  Aw  SRAM address
//  m_wdata_o      out  Dw  SRAM write data
//  m_wmask_o      out  Dw  SRAM write mask
//  m_rdata_i      in   Dw  SRAM read data
//  m_rvalid_i     in   1   SRAM read valid, exactly 1 cycle after a read request
//  core_hold_o    out  1   hold core/system in reset
//  p_ovf_o        out  1   sticky: a programmer write was dropped (FIFO full)
// BEHAVIOUR
//  Reset values:
//   - state=FETCH; FIFO empty; outstanding count=0; hold counter=0.
//   - All outputs 0.
//  FSM:
//   - FETCH: f_gnt_o = (outstanding < MaxOutstand).
//     Each accepted request drives m_req_o/m_we_o/m_addr_o/m_wdata_o/m_wmask_o combinationally from f_*.
//     p_active_i=1 -> DRAIN; f_gnt_o is forced 0 in that same cycle.
//   - DRAIN: f_gnt_o=0; core_hold_o=1.
//     Wait outstanding==0 -> PROG; this takes 0 cycles in DRAIN if already 0.
//   - PROG: f_gnt_o=0; core_hold_o=1.
//     FIFO head pops one write per cycle to SRAM: m_req_o=1, m_we_o=1, m_wmask_o='1.
//     p_active_i=0 -> FLUSH.
//   - FLUSH: keep popping; FIFO empty -> RELEASE; load hold counter with HoldCycles.
//   - RELEASE: core_hold_o=1; counter decrements each cycle; at 0 -> FETCH.
//     p_active_i=1 in RELEASE -> PROG (no drain needed, core held).
//  Outstanding count:
//   - +1 on an accepted read (f_req_i & f_gnt_o & ~f_we_i); -1 on m_rvalid_i.
//   - Both in one cycle leaves it unchanged.
//   - Saturate; never exceeds MaxOutstand.
//  Reads: f_rdata_o=m_rdata_i, f_rvalid_o=m_rvalid_i (passthrough; reads complete in order).
//  Programmer FIFO: p_we_i pushes in any state, including FETCH/DRAIN, where it is buffered.
//   - Push and pop in the same cycle is allowed when full.
//   - Push when full with no pop: word dropped, p_ovf_o set.
//   - p_ovf_o clears only on reset.
//  Reset asserted mid-operation: everything returns to reset values immediately; buffered words are lost.
// TESTING
//  1. Idle fetch:
//     - 3 back-to-back reads at addr 0,1,2 -> f_gnt_o=1 while outstanding<2;
//     - f_rvalid_o 1 cycle after each m_req_o; core_hold_o=0 throughout.
//  2. Drain:
//     - 2 reads outstanding, then p_active_i=1 -> f_gnt_o=0 same cycle;
//     - PROG entered only after 2 rvalids; core_hold_o=1 from the p_active_i cycle.
//  3. Program:
//     - 8 writes (addr 0x000..0x007, data 0xA5A5_0000+i) one per cycle, then p_active_i=0;
//     - SRAM sees all 8 in order with m_wmask_o='1; core_hold_o falls exactly 4 cycles after the last write.
//  4. Overflow:
//     - p_we_i on 3 consecutive cycles while DRAIN is stalled by an outstanding read;
//     - 2 words retained, 3rd dropped, p_ovf_o=1 and stays 1.
//  5. Re-entry:
//     - p_active_i rises during RELEASE -> returns to PROG; core_hold_o never drops.
//  6. Async reset during PROG with 1 word buffered:
//     - all outputs 0 immediately; after release, state is FETCH and FIFO is empty.

Source files
------------

// File: rtl/iccm_port_arbiter.sv
// Shares the single ICCM SRAM port between instruction fetch and the UART boot programmer.
// Latency: fetch requests reach the SRAM combinationally; programmer writes issue one or more cycles after p_we_i.
// Backpressure: fetch stalls via f_gnt_o; the programmer has none, so a write that meets a full buffer is dropped.
module iccm_fifo #(
    parameter int W     = 8,
    parameter int Depth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_vld,
    output logic                       push_rdy,
    input  logic [W-1:0]               push_dat,
    output logic                       pop_vld,
    input  logic                       pop_rdy,
    output logic [W-1:0]               pop_dat,
    output logic [$clog2(Depth+1)-1:0] cnt
);
    localparam int PW = $clog2(Depth);
    localparam int CW = $clog2(Depth + 1);

    logic [W-1:0]  mem [Depth];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;

    assign pop_vld  = (cnt != '0);
    assign pop      = pop_vld & pop_rdy;
    // a full buffer still accepts when the head leaves in the same cycle
    assign push_rdy = (cnt != CW'(Depth)) | pop_rdy;
    assign push     = push_vld & push_rdy;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= push_dat;
    end
endmodule

module iccm_port_arbiter #(
    parameter int Aw          = 12,
    parameter int Dw          = 32,
    parameter int MaxOutstand = 2,
    parameter int WrFifoDepth = 2,
    parameter int HoldCycles  = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          f_req_i,
    output logic          f_gnt_o,
    input  logic          f_we_i,
    input  logic [Aw-1:0] f_addr_i,
    input  logic [Dw-1:0] f_wdata_i,
    input  logic [Dw-1:0] f_wmask_i,
    output logic [Dw-1:0] f_rdata_o,
    output logic          f_rvalid_o,
    input  logic          p_active_i,
    input  logic          p_we_i,
    input  logic [Aw-1:0] p_addr_i,
    input  logic [Dw-1:0] p_wdata_i,
    output logic          m_req_o,
    output logic          m_we_o,
    output logic [Aw-1:0] m_addr_o,
    output logic [Dw-1:0] m_wdata_o,
    output logic [Dw-1:0] m_wmask_o,
    input  logic [Dw-1:0] m_rdata_i,
    input  logic          m_rvalid_i,
    output logic          core_hold_o,
    output logic          p_ovf_o
);
    localparam int OW = $clog2(MaxOutstand + 1);
    localparam int CW = $clog2(WrFifoDepth + 1);
    localparam int HW = (HoldCycles > 0) ? $clog2(HoldCycles + 1) : 1;

    typedef enum logic [2:0] {S_FETCH, S_DRAIN, S_PROG, S_FLUSH, S_RELEASE} state_e;
    typedef struct packed {
        logic [Aw-1:0] addr;
        logic [Dw-1:0] data;
    } wr_t;

    state_e        state_q, state_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          ovf_q;

    wr_t           wr_in, wr_head;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_push_rdy, fifo_pop_vld, fifo_push, fifo_pop, fifo_drained, pop_en;
    logic          f_gnt, rd_acc, hold;
    logic          m_req, m_we;
    logic [Aw-1:0] m_addr;
    logic [Dw-1:0] m_wdata, m_wmask;

    assign wr_in = '{addr: p_addr_i, data: p_wdata_i};

    iccm_fifo #(.W($bits(wr_t)), .Depth(WrFifoDepth)) u_wr_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_vld (p_we_i),
        .push_rdy (fifo_push_rdy),
        .push_dat (wr_in),
        .pop_vld  (fifo_pop_vld),
        .pop_rdy  (pop_en),
        .pop_dat  (wr_head),
        .cnt      (fifo_cnt)
    );

    assign pop_en       = (state_q == S_PROG) || (state_q == S_FLUSH);
    assign fifo_push    = p_we_i & fifo_push_rdy;
    assign fifo_pop     = fifo_pop_vld & pop_en;
    // buffer will be empty after this cycle's pop
    assign fifo_drained = ~fifo_push & (fifo_cnt == CW'(fifo_pop));

    assign f_gnt  = (state_q == S_FETCH) & ~p_active_i & (outst_q < OW'(MaxOutstand));
    assign rd_acc = f_req_i & f_gnt & ~f_we_i;

    always_comb begin
        outst_d = outst_q;
        if (rd_acc && !m_rvalid_i && outst_q != OW'(MaxOutstand)) outst_d = outst_q + 1'b1;
        else if (m_rvalid_i && !rd_acc && outst_q != '0)          outst_d = outst_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        hold    = 1'b1;
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wmask = '0;
        case (state_q)
            S_FETCH: begin
                hold = p_active_i;
                if (f_req_i && f_gnt) begin
                    m_req   = 1'b1;
                    m_we    = f_we_i;
                    m_addr  = f_addr_i;
                    m_wdata = f_wdata_i;
                    m_wmask = f_wmask_i;
                end
                if (p_active_i) state_d = (outst_d == '0) ? S_PROG : S_DRAIN;
            end
            S_DRAIN: begin
                if (outst_d == '0) state_d = S_PROG;
            end
            S_PROG, S_FLUSH: begin
                if (fifo_pop_vld) begin
                    m_req   = 1'b1;
                    m_we    = 1'b1;
                    m_addr  = wr_head.addr;
                    m_wdata = wr_head.data;
                    m_wmask = '1;
                end
                if (p_active_i) begin
                    state_d = S_PROG;
                end else if (fifo_drained) begin
                    state_d = S_RELEASE;
                    hold_d  = HW'(HoldCycles);
                end else begin
                    state_d = S_FLUSH;
                end
            end
            S_RELEASE: begin
                if (hold_q != '0) hold_d = hold_q - 1'b1;
                if (p_active_i)               state_d = S_PROG;
                else if (hold_q <= HW'(1))    state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_FETCH;
            outst_q <= '0;
            hold_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            outst_q <= outst_d;
            hold_q  <= hold_d;
            if (p_we_i && !fifo_push_rdy) ovf_q <= 1'b1;
        end
    end

    // outputs are forced low for as long as reset is asserted, not just from the next edge
    assign f_gnt_o     = rst_ni & f_gnt;
    assign f_rdata_o   = {Dw{rst_ni}} & m_rdata_i;
    assign f_rvalid_o  = rst_ni & m_rvalid_i;
    assign m_req_o     = rst_ni & m_req;
    assign m_we_o      = rst_ni & m_we;
    assign m_addr_o    = {Aw{rst_ni}} & m_addr;
    assign m_wdata_o   = {Dw{rst_ni}} & m_wdata;
    assign m_wmask_o   = {Dw{rst_ni}} & m_wmask;
    assign core_hold_o = rst_ni & hold;
    assign p_ovf_o     = rst_ni & ovf_q;
endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Directed bench for iccm_port_arbiter: a one-cycle-latency SRAM read model plus per-scenario tasks.
module tb_iccm_port_arbiter;
    localparam int Aw = 12;
    localparam int Dw = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          f_req, f_we, f_gnt_o, f_rvalid_o;
    logic [Aw-1:0] f_addr;
    logic [Dw-1:0] f_wdata, f_wmask, f_rdata_o;
    logic          p_active, p_we;
    logic [Aw-1:0] p_addr;
    logic [Dw-1:0] p_wdata;
    logic          m_req_o, m_we_o;
    logic [Aw-1:0] m_addr_o;
    logic [Dw-1:0] m_wdata_o, m_wmask_o, m_rdata_i;
    logic          m_rvalid_i;
    logic          core_hold_o, p_ovf_o;

    logic          stall, force_rv, rv_q;
    logic [Dw-1:0] rdata_q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iccm_port_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .f_req_i     (f_req),
        .f_gnt_o     (f_gnt_o),
        .f_we_i      (f_we),
        .f_addr_i    (f_addr),
        .f_wdata_i   (f_wdata),
        .f_wmask_i   (f_wmask),
        .f_rdata_o   (f_rdata_o),
        .f_rvalid_o  (f_rvalid_o),
        .p_active_i  (p_active),
        .p_we_i      (p_we),
        .p_addr_i    (p_addr),
        .p_wdata_i   (p_wdata),
        .m_req_o     (m_req_o),
        .m_we_o      (m_we_o),
        .m_addr_o    (m_addr_o),
        .m_wdata_o   (m_wdata_o),
        .m_wmask_o   (m_wmask_o),
        .m_rdata_i   (m_rdata_i),
        .m_rvalid_i  (m_rvalid_i),
        .core_hold_o (core_hold_o),
        .p_ovf_o     (p_ovf_o)
    );

    // SRAM model: read data is 0xD0000 concatenated with the word address, valid one cycle later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            rv_q    <= m_req_o & ~m_we_o & ~stall;
            rdata_q <= {20'hD0000, m_addr_o};
        end
    end
    assign m_rvalid_i = rv_q | force_rv;
    assign m_rdata_i  = rdata_q;

    task automatic clear_inputs();
        f_req = 0; f_we = 0; f_addr = '0; f_wdata = '0; f_wmask = '0;
        p_active = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 0; stall = 0; force_rv = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; stall = 0; force_rv = 0;
        clear_inputs();
        f_req = 1;
        #1;
        checks++;
        if ({f_gnt_o, m_req_o, core_hold_o, p_ovf_o, f_rvalid_o} !== 5'b0)
            $display("FAIL reset_outputs got=%b exp=00000", {f_gnt_o, m_req_o, core_hold_o, p_ovf_o, f_rvalid_o});
        if ({f_gnt_o, m_req_o, core_hold_o, p_ovf_o, f_rvalid_o} !== 5'b0) failures++;
        repeat (2) @(negedge clk);
        f_req = 0;
        rst_n = 1;
        #1;
        checks++;
        if ({f_gnt_o, core_hold_o, m_req_o} !== 3'b100) begin
            failures++;
            $display("FAIL reset_release gnt/hold/req got=%b exp=100", {f_gnt_o, core_hold_o, m_req_o});
        end
    endtask

    task automatic test_idle_fetch();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            f_req = (i < 3); f_we = 0; f_addr = 12'(i);
            #1;
            if (i < 3) begin
                checks++;
                if ({f_gnt_o, m_req_o, m_we_o, m_addr_o} !== {3'b110, 12'(i)}) begin
                    failures++;
                    $display("FAIL fetch_req%0d got=%h exp=%h", i, {f_gnt_o, m_req_o, m_we_o, m_addr_o}, {3'b110, 12'(i)});
                end
            end
            checks++;
            if (i > 0 && i < 4) begin
                if ({f_rvalid_o, f_rdata_o} !== {1'b1, 20'hD0000, 12'(i - 1)}) begin
                    failures++;
                    $display("FAIL fetch_rdata%0d got=%h exp=%h", i, {f_rvalid_o, f_rdata_o}, {1'b1, 20'hD0000, 12'(i - 1)});
                end
            end else if (f_rvalid_o !== 1'b0) begin
                failures++;
                $display("FAIL fetch_rvalid_idle%0d got=%b exp=0", i, f_rvalid_o);
            end
            checks++;
            if (core_hold_o !== 1'b0) begin
                failures++;
                $display("FAIL fetch_hold%0d got=%b exp=0", i, core_hold_o);
            end
        end
        // with read data withheld, the third request must see no grant
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            f_req = 1; f_addr = 12'(3 + i);
            #1;
            checks++;
            if ({f_gnt_o, m_req_o} !== {2{i < 2}}) begin
                failures++;
                $display("FAIL fetch_sat%0d got=%b exp=%b", i, {f_gnt_o, m_req_o}, {2{i < 2}});
            end
        end
        @(negedge clk); f_req = 0; force_rv = 1;
        @(negedge clk);
        @(negedge clk); force_rv = 0; stall = 0;
        #1;
        checks++;
        if (f_gnt_o !== 1'b1) begin
            failures++;
            $display("FAIL fetch_regrant got=%b exp=1", f_gnt_o);
        end
    endtask

    task automatic test_drain();
        do_reset();
        stall = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            f_req    = 1;
            f_addr   = 12'h010 + 12'(i);
            p_active = (i >= 2);
            p_we     = (i == 2); p_addr = 12'h020; p_wdata = 32'h0000_1234;
            force_rv = (i == 3 || i == 4);
            #1;
            checks++;
            if ({f_gnt_o, core_hold_o} !== ((i < 2) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL drain_gnt_hold%0d got=%b exp=%b", i, {f_gnt_o, core_hold_o}, (i < 2) ? 2'b10 : 2'b01);
            end
            if (i >= 2 && i < 5) begin
                checks++;
                if (m_req_o !== 1'b0) begin
                    failures++;
                    $display("FAIL drain_no_prog%0d got=%b exp=0", i, m_req_o);
                end
            end
        end
        checks++;
        if ({m_req_o, m_we_o, m_addr_o, m_wdata_o, m_wmask_o} !== {2'b11, 12'h020, 32'h0000_1234, 32'hFFFF_FFFF}) begin
            failures++;
            $display("FAIL drain_first_pop got=%h exp=%h", {m_req_o, m_we_o, m_addr_o, m_wdata_o, m_wmask_o},
                     {2'b11, 12'h020, 32'h0000_1234, 32'hFFFF_FFFF});
        end
        f_req = 0; stall = 0; force_rv = 0;
    endtask

    task automatic test_program();
        do_reset();
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            p_active = (k <= 8);
            p_we     = (k >= 1 && k <= 8);
            p_addr   = 12'(k - 1);
            p_wdata  = 32'hA5A5_0000 + 32'(k - 1);
            #1;
            checks++;
            if (k >= 2 && k <= 9) begin
                if ({m_req_o, m_we_o, m_addr_o, m_wdata_o, m_wmask_o} !==
                    {2'b11, 12'(k - 2), 32'hA5A5_0000 + 32'(k - 2), 32'hFFFF_FFFF}) begin
                    failures++;
                    $display("FAIL prog_wr%0d got=%h exp=%h", k - 2, {m_req_o, m_we_o, m_addr_o, m_wdata_o, m_wmask_o},
                             {2'b11, 12'(k - 2), 32'hA5A5_0000 + 32'(k - 2), 32'hFFFF_FFFF});
                end
            end else if (m_req_o !== 1'b0) begin
                failures++;
                $display("FAIL prog_idle%0d got=%b exp=0", k, m_req_o);
            end
            // last write at k=9: hold stays high for k=10..13, low at k=14
            checks++;
            if (core_hold_o !== (k <= 13)) begin
                failures++;
                $display("FAIL prog_hold%0d got=%b exp=%b", k, core_hold_o, k <= 13);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        stall = 1;
        @(negedge clk); f_req = 1; f_addr = 12'h005;
        @(negedge clk); f_req = 0; p_active = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            p_we = 1; p_addr = 12'h040 + 12'(i); p_wdata = 32'hC0DE_0000 + 32'(i);
            #1;
            checks++;
            if ({p_ovf_o, m_req_o, core_hold_o} !== 3'b001) begin
                failures++;
                $display("FAIL ovf_fill%0d got=%b exp=001", i, {p_ovf_o, m_req_o, core_hold_o});
            end
        end
        @(negedge clk); p_we = 0; force_rv = 1;
        #1;
        checks++;
        if ({p_ovf_o, m_req_o} !== 2'b10) begin
            failures++;
            $display("FAIL ovf_set got=%b exp=10", {p_ovf_o, m_req_o});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); force_rv = 0; p_active = (i < 2);
            #1;
            checks++;
            if (i < 2) begin
                if ({m_req_o, m_addr_o, m_wdata_o} !== {1'b1, 12'h040 + 12'(i), 32'hC0DE_0000 + 32'(i)}) begin
                    failures++;
                    $display("FAIL ovf_kept%0d got=%h exp=%h", i, {m_req_o, m_addr_o, m_wdata_o},
                             {1'b1, 12'h040 + 12'(i), 32'hC0DE_0000 + 32'(i)});
                end
            end else if (m_req_o !== 1'b0) begin
                failures++;
                $display("FAIL ovf_dropped got=%b exp=0", m_req_o);
            end
        end
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if ({p_ovf_o, core_hold_o} !== 2'b10) begin
            failures++;
            $display("FAIL ovf_sticky got=%b exp=10", {p_ovf_o, core_hold_o});
        end
        stall = 0;
    endtask

    task automatic test_reentry();
        do_reset();
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            p_active = (k == 0 || k == 3 || k == 4);
            p_we     = (k == 0 || k == 3);
            p_addr   = (k == 0) ? 12'h080 : 12'h081;
            p_wdata  = (k == 0) ? 32'h1111_0000 : 32'h2222_0000;
            #1;
            checks++;
            if (core_hold_o !== (k <= 9)) begin
                failures++;
                $display("FAIL reentry_hold%0d got=%b exp=%b", k, core_hold_o, k <= 9);
            end
            checks++;
            if (k == 1 || k == 4) begin
                if ({m_req_o, m_addr_o} !== {1'b1, (k == 1) ? 12'h080 : 12'h081}) begin
                    failures++;
                    $display("FAIL reentry_wr%0d got=%h exp=%h", k, {m_req_o, m_addr_o}, {1'b1, (k == 1) ? 12'h080 : 12'h081});
                end
            end else if (m_req_o !== 1'b0) begin
                failures++;
                $display("FAIL reentry_idle%0d got=%b exp=0", k, m_req_o);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk); p_active = 1;
        @(negedge clk); p_we = 1; p_addr = 12'h090; p_wdata = 32'h0000_9999;
        @(negedge clk); p_we = 0;
        #1;
        checks++;
        if ({core_hold_o, m_req_o, m_addr_o} !== {2'b11, 12'h090}) begin
            failures++;
            $display("FAIL arst_pre got=%h exp=%h", {core_hold_o, m_req_o, m_addr_o}, {2'b11, 12'h090});
        end
        #1 rst_n = 0;
        #1;
        checks++;
        if ({f_gnt_o, m_req_o, m_we_o, m_addr_o, m_wdata_o, m_wmask_o, core_hold_o, p_ovf_o, f_rvalid_o, f_rdata_o} !== '0) begin
            failures++;
            $display("FAIL arst_outputs got=%h exp=0",
                     {f_gnt_o, m_req_o, m_we_o, m_addr_o, m_wdata_o, m_wmask_o, core_hold_o, p_ovf_o, f_rvalid_o, f_rdata_o});
        end
        @(negedge clk);
        @(negedge clk); rst_n = 1; p_active = 0;
        #1;
        checks++;
        if ({f_gnt_o, core_hold_o, m_req_o} !== 3'b100) begin
            failures++;
            $display("FAIL arst_fetch got=%b exp=100", {f_gnt_o, core_hold_o, m_req_o});
        end
        @(negedge clk); p_active = 1;
        @(negedge clk);
        #1;
        // back in PROG: a surviving buffered word would show up as a write here
        checks++;
        if ({core_hold_o, m_req_o} !== 2'b10) begin
            failures++;
            $display("FAIL arst_fifo_empty got=%b exp=10", {core_hold_o, m_req_o});
        end
        p_active = 0;
    endtask

    initial begin
        test_reset();
        test_idle_fetch();
        test_drain();
        test_program();
        test_overflow();
        test_reentry();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
